// File: rtl/edge_event_arbiter.sv
// Rising-edge detector feeding a round-robin, one-event-per-channel scheduler over valid/ready.
// Optional macro EDGE_ARB_SYNC_EN inserts a 2-flop synchroniser on every level input.
module edge_event_arbiter #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   level,
    input  logic           evt_ready,
    input  logic           clr_overflow,
    output logic           evt_valid,
    output logic [IDW-1:0] evt_id,
    output logic [N-1:0]   pending,
    output logic [N-1:0]   overflow
);

    typedef enum logic [1:0] {
        StIdle  = 2'b01,
        StOffer = 2'b10
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   lvl;
    logic [N-1:0]   prev_q, prev_d;
    logic [N-1:0]   rise;
    logic [N-1:0]   accept_vec;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   overflow_q, overflow_d;
    logic [IDW-1:0] evt_id_q, evt_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic           accept;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] search_id;
    int unsigned    search_idx;

`ifdef EDGE_ARB_SYNC_EN
    logic [N-1:0] sync1_q, sync1_d;
    logic [N-1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = level;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign lvl = sync2_q;
`else
    assign lvl = level;
`endif

    // Only an offered event can be accepted; ready while idle is ignored.
    assign accept = (state_q == StOffer) & evt_ready;

    always_comb begin
        prev_d = lvl;
        rise   = lvl & ~prev_q;
        for (int unsigned i = 0; i < N; i++) begin
            accept_vec[i] = accept & (evt_id_q == IDW'(i));
        end
    end

    // A rise coincident with acceptance re-arms the channel; a rise onto an
    // unaccepted pending event is lost and recorded, winning over a clear.
    always_comb begin
        pending_d  = rise | (pending_q & ~accept_vec);
        overflow_d = (rise & pending_q & ~accept_vec) | (overflow_q & {N{~clr_overflow}});
    end

    // Round-robin search starting at ptr, wrapping explicitly at N-1.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        search_idx  = 0;
        search_id   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            search_idx = 32'(ptr_q) + k;
            if (search_idx >= N) begin
                search_idx = search_idx - N;
            end
            search_id = IDW'(search_idx);
            if (!grant_found && pending_q[search_id]) begin
                grant_found = 1'b1;
                grant_id    = search_id;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        evt_id_d = evt_id_q;
        ptr_d    = ptr_q;
        case (state_q)
            StIdle: begin
                if (grant_found) begin
                    state_d  = StOffer;
                    evt_id_d = grant_id;
                end
            end
            StOffer: begin
                if (evt_ready) begin
                    state_d = StIdle;
                    if (evt_id_q == IDW'(N - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = evt_id_q + IDW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            prev_q     <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
            evt_id_q   <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            evt_id_q   <= evt_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign evt_valid = (state_q == StOffer);
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Self-checking bench for edge_event_arbiter: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the event queue.
module tb_edge_event_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
`ifdef EDGE_ARB_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   level_r = '0;
    logic           rdy_r = 1'b0;
    logic           clr_r = 1'b0;
    logic           evt_valid;
    logic [IDW-1:0] evt_id;
    logic [N-1:0]   pending;
    logic [N-1:0]   overflow;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [N-1:0] m_prev, m_pend, m_ovf, m_s1, m_s2;
    logic         m_valid;
    int           m_id, m_ptr;

    edge_event_arbiter #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .level       (level_r),
        .evt_ready   (rdy_r),
        .clr_overflow(clr_r),
        .evt_valid   (evt_valid),
        .evt_id      (evt_id),
        .pending     (pending),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_prev  = '0;
        m_pend  = '0;
        m_ovf   = '0;
        m_s1    = '0;
        m_s2    = '0;
        m_valid = 1'b0;
        m_id    = 0;
        m_ptr   = 0;
    endfunction

    function automatic void model_step();
        logic [N-1:0] lv;
        logic [N-1:0] old_pend;
        logic         acc;
        logic         r, a;
`ifdef EDGE_ARB_SYNC_EN
        lv   = m_s2;
        m_s2 = m_s1;
        m_s1 = level_r;
`else
        lv = level_r;
`endif
        acc      = m_valid && rdy_r;
        old_pend = m_pend;
        for (int i = 0; i < N; i++) begin
            r = lv[i] && !m_prev[i];
            a = acc && (m_id == i);
            m_pend[i] = r || (old_pend[i] && !a);
            m_ovf[i]  = (r && old_pend[i] && !a) || (m_ovf[i] && !clr_r);
            m_prev[i] = lv[i];
        end
        if (m_valid) begin
            if (acc) begin
                m_valid = 1'b0;
                m_ptr   = (m_id + 1) % N;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!m_valid && old_pend[(m_ptr + k) % N]) begin
                    m_valid = 1'b1;
                    m_id    = (m_ptr + k) % N;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset == 1'b0) model_step();
        #1;
    endtask

    task automatic tick_n(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        level_r = '0;
        rdy_r   = 1'b0;
        clr_r   = 1'b0;
        model_reset();
        tick_n(2);
        reset = 1'b0;
        tick();
    endtask

    // Records each offered id while ready is held high; cnt grants or budget expiry.
    task automatic collect_grants(input int cnt, output int ids[8], output int got);
        got = 0;
        for (int c = 0; c < 40 && got < cnt; c++) begin
            tick();
            if (evt_valid === 1'b1) begin
                ids[got] = int'(evt_id);
                got++;
            end
        end
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", evt_valid); end
        total++; if (evt_id !== 2'd0) begin bad++; $display("FAIL rst_id got=%0d exp=0", evt_id); end
        total++; if (pending !== 4'b0) begin bad++; $display("FAIL rst_pending got=%b exp=0000", pending); end
        total++; if (overflow !== 4'b0) begin bad++; $display("FAIL rst_overflow got=%b exp=0000", overflow); end
        tick_n(2);
        reset = 1'b0;
        tick_n(2);
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL post_rst_valid got=%b exp=0", evt_valid); end
        total++; if (pending !== 4'b0) begin bad++; $display("FAIL post_rst_pending got=%b exp=0000", pending); end
    endtask

    task automatic test_single_event();
        int hs;
        rdy_r   = 1'b1;
        level_r = 4'b0100;
        tick_n(LAT);
        tick();
        total++; if (pending !== 4'b0100) begin bad++; $display("FAIL single_pending got=%b exp=0100", pending); end
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL single_valid_early got=%b exp=0", evt_valid); end
        tick();
        total++; if (evt_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", evt_valid); end
        total++; if (evt_id !== 2'd2) begin bad++; $display("FAIL single_id got=%0d exp=2", evt_id); end
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (evt_valid === 1'b1) hs++;
        end
        total++; if (hs !== 0) begin bad++; $display("FAIL single_extra_events got=%0d exp=0", hs); end
        total++; if (pending !== 4'b0) begin bad++; $display("FAIL single_pending_clr got=%b exp=0000", pending); end
        level_r = '0;
        tick_n(LAT + 1);
    endtask

    task automatic test_round_robin();
        int ids[8];
        int got;
        do_reset();
        rdy_r   = 1'b1;
        level_r = '1;
        collect_grants(4, ids, got);
        total++; if (got !== 4) begin bad++; $display("FAIL rr0_count got=%0d exp=4", got); end
        for (int k = 0; k < got; k++) begin
            total++; if (ids[k] !== k) begin bad++; $display("FAIL rr0_order[%0d] got=%0d exp=%0d", k, ids[k], k); end
        end
        level_r = '0;
        tick_n(LAT + 2);
        do_reset();
        rdy_r   = 1'b1;
        level_r = 4'b0010;
        collect_grants(1, ids, got);
        total++; if (got !== 1 || ids[0] !== 1) begin bad++; $display("FAIL rr_prime got=%0d/%0d exp=1/1", got, ids[0]); end
        level_r = '0;
        tick_n(LAT + 2);
        level_r = '1;
        collect_grants(4, ids, got);
        total++; if (got !== 4) begin bad++; $display("FAIL rr2_count got=%0d exp=4", got); end
        for (int k = 0; k < got; k++) begin
            total++; if (ids[k] !== (2 + k) % 4) begin bad++; $display("FAIL rr2_order[%0d] got=%0d exp=%0d", k, ids[k], (2 + k) % 4); end
        end
        level_r = '0;
        tick_n(LAT + 3);
    endtask

    task automatic test_backpressure();
        int err;
        do_reset();
        level_r = 4'b0010;
        tick_n(LAT + 2);
        total++; if (evt_valid !== 1'b1 || evt_id !== 2'd1) begin bad++; $display("FAIL bp_offer got=%b/%0d exp=1/1", evt_valid, evt_id); end
        level_r = 4'b1010;
        err = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (evt_valid !== 1'b1 || evt_id !== 2'd1) err++;
        end
        total++; if (err !== 0) begin bad++; $display("FAIL bp_hold got=%0d bad cycles exp=0", err); end
        total++; if (pending[3] !== 1'b1) begin bad++; $display("FAIL bp_pending3 got=%b exp=1", pending[3]); end
        rdy_r = 1'b1;
        tick();
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL bp_gap got=%b exp=0", evt_valid); end
        tick();
        total++; if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin bad++; $display("FAIL bp_next got=%b/%0d exp=1/3", evt_valid, evt_id); end
        level_r = '0;
        tick_n(LAT + 3);
    endtask

    task automatic test_overflow();
        int dl;
        do_reset();
        level_r = 4'b0001; tick(); level_r = '0; tick_n(LAT + 2);
        level_r = 4'b0001; tick(); level_r = '0; tick_n(LAT + 2);
        total++; if (overflow !== 4'b0001) begin bad++; $display("FAIL ovf_set got=%b exp=0001", overflow); end
        total++; if (pending[0] !== 1'b1) begin bad++; $display("FAIL ovf_pending got=%b exp=1", pending[0]); end
        dl = (evt_valid === 1'b1 && evt_id === 2'd0) ? 1 : 0;
        rdy_r = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (evt_valid === 1'b1) dl++;
        end
        total++; if (dl !== 1) begin bad++; $display("FAIL ovf_deliveries got=%0d exp=1", dl); end
        rdy_r = 1'b0;
        clr_r = 1'b1; tick(); clr_r = 1'b0;
        total++; if (overflow !== 4'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0000", overflow); end
        level_r = 4'b0001; tick(); level_r = '0; tick_n(LAT + 2);
        level_r = 4'b0001;
        tick_n(LAT);
        clr_r = 1'b1; tick(); clr_r = 1'b0;
        total++; if (overflow[0] !== 1'b1) begin bad++; $display("FAIL ovf_set_beats_clr got=%b exp=1", overflow[0]); end
        clr_r = 1'b1; tick(); clr_r = 1'b0;
        level_r = '0;
        tick_n(LAT + 1);
        level_r = 4'b0001;
        tick_n(LAT);
        rdy_r = 1'b1; tick(); rdy_r = 1'b0;
        total++; if (pending[0] !== 1'b1 || evt_valid !== 1'b0) begin bad++; $display("FAIL acc_rise got=%b/%b exp=1/0", pending[0], evt_valid); end
        total++; if (overflow[0] !== 1'b0) begin bad++; $display("FAIL acc_rise_ovf got=%b exp=0", overflow[0]); end
        tick();
        total++; if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin bad++; $display("FAIL acc_rise_second got=%b/%0d exp=1/0", evt_valid, evt_id); end
        level_r = '0;
        rdy_r   = 1'b1;
        tick_n(LAT + 3);
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        level_r = 4'b0100; tick(); level_r = '0; tick_n(LAT + 2);
        level_r = 4'b0100; tick(); level_r = '0; tick_n(LAT + 2);
        total++; if (evt_valid !== 1'b1 || overflow !== 4'b0100) begin bad++; $display("FAIL mid_pre got=%b/%b exp=1/0100", evt_valid, overflow); end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        total++; if (evt_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", evt_valid); end
        total++; if (pending !== 4'b0) begin bad++; $display("FAIL mid_pending got=%b exp=0000", pending); end
        total++; if (overflow !== 4'b0) begin bad++; $display("FAIL mid_overflow got=%b exp=0000", overflow); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) level_r[i] = ~level_r[i];
            end
            rdy_r = ($urandom_range(0, 2) != 0);
            clr_r = ($urandom_range(0, 15) == 0);
            tick();
            total++; if (evt_valid !== m_valid) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, evt_valid, m_valid); end
            total++; if (pending !== m_pend) begin bad++; $display("FAIL rnd_pending c=%0d got=%b exp=%b", c, pending, m_pend); end
            total++; if (overflow !== m_ovf) begin bad++; $display("FAIL rnd_overflow c=%0d got=%b exp=%b", c, overflow, m_ovf); end
            if (m_valid) begin
                total++; if (int'(evt_id) !== m_id) begin bad++; $display("FAIL rnd_id c=%0d got=%0d exp=%0d", c, evt_id, m_id); end
            end
        end
        clr_r = 1'b0;
        rdy_r = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_round_robin();
        test_backpressure();
        test_overflow();
        test_reset_mid_offer();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
